// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds an even-parity bit after the data bits).
package serial_pkg;

  localparam int DATA_W = 8;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } tx_state_e;
`endif

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// FIFO-side handshake and serial line outputs of serial_tx.
// master: the transmitter; slave: the FIFO / line observer.
interface serial_tx_if;
  import serial_pkg::*;

  logic [DATA_W-1:0] Fdata;
  logic              Fempty;
  logic              Ren;
  logic              TxD;
  logic              Busy;

  modport master (input Fdata, input Fempty, output Ren, output TxD, output Busy);
  modport slave  (output Fdata, output Fempty, input Ren, input TxD, input Busy);

endinterface

// File: rtl/serial_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, restarts on load,
// and flags the last cycle of each bit period.
module baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic ck,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Bit-period counter: cleared on load or when idle, wraps at the bit boundary.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter fed from a FIFO head (Fdata/Fempty, active-low Ren pop).
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1); back-to-back frames
// have no idle gap. Define SERIAL_TX_PARITY_EN to add the parity bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic ck,
  input  logic rst,
  serial_tx_if.master bus
);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_bit_idx;
  logic              r_txd;
  logic              r_ren;
  logic              r_busy;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_par;
`endif

  logic w_load;
  logic w_en;
  logic w_bit_end;

  assign w_en = (r_state != ST_IDLE);

  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .ck       (ck),
    .rst      (rst),
    .i_load   (w_load),
    .i_en     (w_en),
    .o_bit_end(w_bit_end)
  );

  // Load decision: FIFO is sampled only in IDLE or on the last stop-bit cycle.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: w_load = ~bus.Fempty;
      ST_STOP: w_load = w_bit_end & ~bus.Fempty;
      default: w_load = 1'b0;
    endcase
  end

  // Transmit FSM with registered TxD, Ren and Busy.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= 3'd0;
      r_txd     <= 1'b1;
      r_ren     <= 1'b1;
      r_busy    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_ren <= 1'b1;
      if (w_load) begin
        r_shift   <= bus.Fdata;
        r_bit_idx <= 3'd0;
        r_txd     <= 1'b0;
        r_ren     <= 1'b0;
        r_busy    <= 1'b1;
        r_state   <= ST_START;
`ifdef SERIAL_TX_PARITY_EN
        r_par     <= even_parity(bus.Fdata);
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_txd  <= 1'b1;
            r_busy <= 1'b0;
          end
          ST_START: begin
            if (w_bit_end) begin
              r_state   <= ST_DATA;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
              r_bit_idx <= 3'd0;
            end
          end
          ST_DATA: begin
            if (w_bit_end) begin
              if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                r_state <= ST_PARITY;
                r_txd   <= r_par;
`else
                r_state <= ST_STOP;
                r_txd   <= 1'b1;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_txd     <= r_shift[0];
                r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
              end
            end
          end
`ifdef SERIAL_TX_PARITY_EN
          ST_PARITY: begin
            if (w_bit_end) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end
          end
`endif
          ST_STOP: begin
            // Reaching here at bit end means no byte was waiting.
            if (w_bit_end) begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.TxD  = r_txd;
  assign bus.Ren  = r_ren;
  assign bus.Busy = r_busy;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx with CLKS_PER_BIT=4.
module tb_serial_tx;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * CPB;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } vec_t;

  logic ck = 1'b0;
  logic rst = 1'b1;

  serial_tx_if bus ();

  serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .ck (ck),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 ck = ~ck;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // FIFO model: written by the stimulus, popped on observed Ren
  logic [7:0] fifo_mem [0:15];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  logic       manual = 1'b0;
  logic       man_empty = 1'b1;
  logic [7:0] man_data = 8'h00;
  logic [3:0] rd_idx;

  assign rd_idx     = fifo_rd[3:0];
  assign bus.Fempty = manual ? man_empty : (fifo_rd == fifo_wr);
  assign bus.Fdata  = manual ? man_data : fifo_mem[rd_idx];

  // scoreboard and monitor state
  vec_t        sb_q [$];
  int          ren_log [$];
  int          ren_cnt = 0;
  int          frames_done = 0;
  logic        mon_active = 1'b0;
  int          mon_cnt = 0;
  vec_t        mon_exp;
  logic [43:0] obs_tx;
  logic [43:0] obs_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_bits(input vec_t v);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, v.p, v.d, 1'b0};
`else
    return {1'b0, 1'b1, v.d, 1'b0};
`endif
  endfunction

  function automatic logic [43:0] expand(input logic [10:0] f);
    logic [43:0] r;
    r = '0;
    for (int i = 0; i < FRAME_CYC; i++) r[i] = f[i / CPB];
    return r;
  endfunction

  always @(posedge ck) cyc++;

  // FIFO pop when the DUT's Ren is seen low
  always @(negedge ck) begin
    if (!manual && !rst && bus.Ren === 1'b0 && fifo_rd != fifo_wr) fifo_rd++;
  end

  // Monitor: capture each frame from its Ren cycle and compare with the scoreboard
  always @(negedge ck) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (bus.Ren === 1'b0) begin
        ren_cnt++;
        ren_log.push_back(cyc);
        if (mon_active) chk("ren_in_frame", 64'(mon_cnt), 64'(FRAME_CYC));
        chk("ren_expected", 64'(sb_q.size() > 0), 64'd1);
        mon_exp    = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        mon_active = 1'b1;
        mon_cnt    = 0;
        obs_tx     = '0;
        obs_busy   = '0;
      end
      if (mon_active) begin
        obs_tx[mon_cnt]   = bus.TxD;
        obs_busy[mon_cnt] = bus.Busy;
        mon_cnt++;
        if (mon_cnt == FRAME_CYC) begin
          chk($sformatf("frame_txd_%02h", mon_exp.d), 64'(obs_tx), 64'(expand(frame_bits(mon_exp))));
          chk($sformatf("frame_busy_%02h", mon_exp.d), 64'(obs_busy), 64'((44'd1 << FRAME_CYC) - 44'd1));
          mon_active = 1'b0;
          frames_done++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p);
    @(negedge ck);
    sb_q.push_back('{d: d, p: p});
    fifo_mem[fifo_wr[3:0]] = d;
    fifo_wr++;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge ck);
      n++;
    end
    chk("frame_timeout", 64'(frames_done >= target), 64'd1);
  endtask

  task automatic check_idle(input string name);
    @(negedge ck);
    chk(name, {61'd0, bus.TxD, bus.Ren, bus.Busy}, 64'b110);
  endtask

  vec_t vecs [7];

  initial begin
    int r0, f0, viol, n, l0;

    vecs[0] = '{d: 8'hA5, p: 1'b0};
    vecs[1] = '{d: 8'h07, p: 1'b1};
    vecs[2] = '{d: 8'h03, p: 1'b0};
    vecs[3] = '{d: 8'h01, p: 1'b1};
    vecs[4] = '{d: 8'h80, p: 1'b1};
    vecs[5] = '{d: 8'h6E, p: 1'b1};
    vecs[6] = '{d: 8'hC3, p: 1'b0};
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;

    // reset held 3 cycles, then 100 idle cycles with an empty FIFO
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk("reset_outputs", {61'd0, bus.TxD, bus.Ren, bus.Busy}, 64'b110);
    end
    rst = 1'b0;
    viol = 0;
    repeat (100) begin
      @(negedge ck);
      if ({bus.TxD, bus.Ren, bus.Busy} !== 3'b110) viol++;
    end
    chk("idle_100_violations", 64'(viol), 64'd0);
    chk("idle_no_ren", 64'(ren_cnt), 64'd0);

    // table-driven single frames
    for (int i = 0; i < 7; i++) begin
      r0 = ren_cnt;
      f0 = frames_done;
      send(vecs[i].d, vecs[i].p);
      wait_frames(f0 + 1, 4 * FRAME_CYC);
      check_idle($sformatf("idle_after_%02h", vecs[i].d));
      chk($sformatf("ren_pulses_%02h", vecs[i].d), 64'(ren_cnt - r0), 64'd1);
    end

    // back-to-back 0x00 then 0xFF: Ren pulses one frame apart, no idle gap
    r0 = ren_cnt;
    f0 = frames_done;
    l0 = ren_log.size();
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    wait_frames(f0 + 2, 6 * FRAME_CYC);
    check_idle("idle_after_b2b");
    chk("b2b_ren_pulses", 64'(ren_cnt - r0), 64'd2);
    if (ren_log.size() >= l0 + 2)
      chk("b2b_ren_spacing", 64'(ren_log[l0 + 1] - ren_log[l0]), 64'(FRAME_CYC));
    else
      chk("b2b_ren_log", 64'(ren_log.size() - l0), 64'd2);

    // reset during data bit 3 of 0x3C
    r0 = ren_cnt;
    f0 = frames_done;
    send(8'h3C, 1'b0);
    n = 0;
    while (ren_cnt == r0 && n < 20) begin
      @(negedge ck);
      n++;
    end
    chk("mid_rst_ren_seen", 64'(ren_cnt - r0), 64'd1);
    repeat (17) @(posedge ck);
    #1;
    chk("mid_rst_pre_state", {62'd0, bus.TxD, bus.Busy}, 64'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", {61'd0, bus.TxD, bus.Ren, bus.Busy}, 64'b110);
    @(negedge ck);
    @(negedge ck);
    rst = 1'b0;
    repeat (10) @(negedge ck);
    chk("mid_rst_no_pop", 64'(ren_cnt - r0), 64'd1);
    chk("mid_rst_no_frame", 64'(frames_done - f0), 64'd0);
    chk("mid_rst_idle", {61'd0, bus.TxD, bus.Ren, bus.Busy}, 64'b110);
    r0 = ren_cnt;
    send(8'h81, 1'b0);
    wait_frames(f0 + 1, 4 * FRAME_CYC);
    check_idle("idle_after_81");
    chk("ren_pulses_81", 64'(ren_cnt - r0), 64'd1);

    // Fempty stays low one cycle past the load edge, then rises
    r0 = ren_cnt;
    f0 = frames_done;
    @(negedge ck);
    man_empty = 1'b1;
    man_data  = 8'h5A;
    manual    = 1'b1;
    @(negedge ck);
    sb_q.push_back('{d: 8'h5A, p: 1'b0});
    man_empty = 1'b0;
    @(posedge ck);
    @(posedge ck);
    #1;
    man_empty = 1'b1;
    wait_frames(f0 + 1, 4 * FRAME_CYC);
    repeat (10) @(negedge ck);
    chk("late_empty_ren_pulses", 64'(ren_cnt - r0), 64'd1);
    chk("late_empty_idle", {61'd0, bus.TxD, bus.Ren, bus.Busy}, 64'b110);
    manual = 1'b0;

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
